fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
Round-robin arbiter that shares the single write port of the team's asynchronous FIFO between NREQ requesters, all in the write clock domain. It grants one requester at a time and drives the FIFO write port for one cycle per word. It checks the FIFO's registered overflow flag after each write and retries a rejected word after a back-off, or drops it after MAX_RETRY retries. Each word is reported to its owner as accepted or dropped.

Parameters:
ID_W, 2, requester index width; NREQ = 2**ID_W (default 4)
WORDSIZE, 8, data width; matches FIFO data_in
RETRY_WAIT, 4, back-off cycles between a rejected write and its retry (>=1)
MAX_RETRY, 7, retries after the first rejection before the word is dropped (0 = drop on first rejection)

Ports:
wr_clk  in  1  write-domain clock, all logic on posedge
init  in  1  synchronous active-high reset
req  in  NREQ  request per requester; held with req_data stable until own ack or drop
req_data  in  NREQ*WORDSIZE  packed data; requester i at [i*WORDSIZE +: WORDSIZE]
ack  out  NREQ  one-cycle pulse: word accepted by FIFO
drop  out  NREQ  one-cycle pulse: word abandoned after retries exhausted
fifo_data_in  out  WORDSIZE  to FIFO data_in
fifo_write_en  out  1  to FIFO write_en
fifo_overflow  in  1  from FIFO overflow (updates only on cycles with write_en=1)
grant_id  out  ID_W  index of the current or last granted requester
busy  out  1  high in any state other than IDLE
wr_count  out  16  accepted-word counter, wraps at 2**16

Behaviour:
- All outputs registered. init has priority over everything. init=1 -> state IDLE, rr_ptr=0, retry_cnt=0, wait_cnt=0, ack=drop=0, fifo_write_en=0, fifo_data_in=0, grant_id=0, busy=0, wr_count=0. An in-flight word is abandoned with no ack or drop.
- FSM states IDLE, WRITE, CHECK, BACKOFF.
- IDLE:
  - Eligible = req with the bit of any requester whose ack or drop is high this cycle masked. This prevents a double write while that requester's req is still high.
  - If any requester is eligible, pick the first one in order rr_ptr, rr_ptr+1, ... modulo NREQ.
  - Capture its req_data into fifo_data_in, set grant_id, clear retry_cnt, and go to WRITE.
  - With no eligible requester, stay in IDLE.
- WRITE: fifo_write_en=1 for exactly this one cycle with fifo_data_in stable; go to CHECK.
- CHECK: fifo_write_en=0; sample fifo_overflow, which reflects the result of the WRITE cycle.
  - 0: ack[grant_id]=1 next cycle, wr_count+1, rr_ptr=grant_id+1 (mod NREQ), go to IDLE.
  - 1 and retry_cnt==MAX_RETRY: drop[grant_id]=1 next cycle, rr_ptr=grant_id+1, go to IDLE; wr_count unchanged.
  - 1 otherwise: retry_cnt+1, wait_cnt=RETRY_WAIT-1, go to BACKOFF.
- BACKOFF: when wait_cnt==0, go to WRITE with the same captured data; otherwise decrement wait_cnt.
- ack and drop are high only in the first IDLE cycle after CHECK; at most one bit of ack|drop is set at any time.
- Latency:
  - Grant at edge T, write_en high in cycle T+1, ack high in cycle T+3.
  - Best-case throughput is one word per 3 cycles.
  - Retry period is 2+RETRY_WAIT cycles between write_en pulses.
- req deasserted after grant is ignored: the captured word is still written and acked or dropped.
- req_data is sampled only at the grant edge.
- fifo_overflow is ignored outside CHECK.

Test Plan:
1. req=0010, req_data[1]=0xA5, fifo_overflow=0 -> fifo_write_en one cycle with fifo_data_in=0xA5, grant_id=1, ack=0010 two cycles later, wr_count=1.
2. req=1111 held, distinct data, overflow=0 -> grants 0,1,2,3,0,... every 3 cycles, each ack matches its requester's data, wr_count=N after N words.
3. fifo_overflow forced 1 after every write, defaults -> 8 write_en pulses 6 cycles apart with identical data, then drop pulse for that requester, no ack, wr_count unchanged.
4. overflow=1 for the first 2 writes, then 0 -> 3 write_en pulses with the same data, single ack on the third, wr_count+1.
5. init=1 during BACKOFF -> next cycle IDLE, busy=0, fifo_write_en=0, wr_count=0, no ack or drop; after release the arbiter restarts from requester 0.
6. Only requester 2 holds req and updates data on each ack (0x01, 0x02, 0x03) -> exactly three writes with data 0x01, 0x02, 0x03, no duplicate write in the ack cycle.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin owner of the async FIFO write port.
//
// NREQ = 2**ID_W requesters, all in the write clock domain, share a single
// FIFO write port. A granted word is written for one cycle. The FIFO's
// registered overflow flag is then checked. A rejected word is retried after
// RETRY_WAIT cycles of back-off. It is dropped after MAX_RETRY retries. The
// owner of each word gets a one-cycle ack or drop pulse.
//
// Ports:
//   wr_clk         write-domain clock (posedge)
//   init           synchronous active-high reset, overrides everything
//   req            per-requester request, held until own ack/drop
//   req_data       packed request data, requester i at [i*WORDSIZE +: WORDSIZE]
//   ack / drop     one-cycle per-requester result pulses
//   fifo_data_in   FIFO data_in
//   fifo_write_en  FIFO write_en
//   fifo_overflow  FIFO overflow (valid in the cycle after a write)
//   grant_id       current or last granted requester
//   busy           FSM not in IDLE
//   wr_count       accepted-word counter (wraps)

// Per-requester slice: eligibility mask and result pulse decode.
module fifo_wr_arb_lane #(
  parameter int ID_W = 2,
  parameter int LANE = 0
) (
  input  logic            req,
  input  logic            ack_q,
  input  logic            drop_q,
  input  logic            ack_fire,
  input  logic            drop_fire,
  input  logic [ID_W-1:0] grant_id,
  output logic            elig,
  output logic            ack_d,
  output logic            drop_d
);
  logic sel;

  assign sel    = (grant_id == ID_W'(LANE));
  // A requester still sees its own req high during its ack/drop cycle.
  // Masking it here stops the same word being written twice.
  assign elig   = req & ~ack_q & ~drop_q;
  assign ack_d  = ack_fire & sel;
  assign drop_d = drop_fire & sel;
endmodule

module fifo_wr_arbiter #(
  parameter  int ID_W       = 2,
  parameter  int WORDSIZE   = 8,
  parameter  int RETRY_WAIT = 4,
  parameter  int MAX_RETRY  = 7,
  localparam int NREQ       = 1 << ID_W
) (
  input  logic                     wr_clk,
  input  logic                     init,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WORDSIZE-1:0] req_data,
  output logic [NREQ-1:0]          ack,
  output logic [NREQ-1:0]          drop,
  output logic [WORDSIZE-1:0]      fifo_data_in,
  output logic                     fifo_write_en,
  input  logic                     fifo_overflow,
  output logic [ID_W-1:0]          grant_id,
  output logic                     busy,
  output logic [15:0]              wr_count
);
  localparam int RC_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int WC_W = (RETRY_WAIT > 1) ? $clog2(RETRY_WAIT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_CHECK, S_BACKOFF} state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [RC_W-1:0]     retry_cnt_q, retry_cnt_d;
  logic [WC_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic [NREQ-1:0]     ack_q, ack_d;
  logic [NREQ-1:0]     drop_q, drop_d;
  logic                fifo_we_q, fifo_we_d;
  logic [WORDSIZE-1:0] fifo_data_q, fifo_data_d;
  logic [ID_W-1:0]     grant_id_q, grant_id_d;
  logic                busy_q, busy_d;
  logic [15:0]         wr_count_q, wr_count_d;

  logic [NREQ-1:0]     elig;
  logic                ack_fire, drop_fire;
  logic                pick_vld;
  logic [ID_W-1:0]     pick_id;

  for (genvar g = 0; g < NREQ; g++) begin : g_lane
    fifo_wr_arb_lane #(.ID_W(ID_W), .LANE(g)) u_lane (
      .req      (req[g]),
      .ack_q    (ack_q[g]),
      .drop_q   (drop_q[g]),
      .ack_fire (ack_fire),
      .drop_fire(drop_fire),
      .grant_id (grant_id_q),
      .elig     (elig[g]),
      .ack_d    (ack_d[g]),
      .drop_d   (drop_d[g])
    );
  end

  // Round-robin search starting at rr_ptr. The loop walks from the farthest
  // offset to the nearest, so the nearest eligible requester wins.
  always_comb begin
    logic [ID_W-1:0] idx;
    idx      = '0;
    pick_vld = 1'b0;
    pick_id  = rr_ptr_q;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = rr_ptr_q + ID_W'(i);
      if (elig[idx]) begin
        pick_vld = 1'b1;
        pick_id  = idx;
      end
    end
  end

  // State register (all flops)
  always_ff @(posedge wr_clk) begin
    if (init) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      retry_cnt_q <= '0;
      wait_cnt_q  <= '0;
      ack_q       <= '0;
      drop_q      <= '0;
      fifo_we_q   <= 1'b0;
      fifo_data_q <= '0;
      grant_id_q  <= '0;
      busy_q      <= 1'b0;
      wr_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      retry_cnt_q <= retry_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      ack_q       <= ack_d;
      drop_q      <= drop_d;
      fifo_we_q   <= fifo_we_d;
      fifo_data_q <= fifo_data_d;
      grant_id_q  <= grant_id_d;
      busy_q      <= busy_d;
      wr_count_q  <= wr_count_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    retry_cnt_d = retry_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    fifo_data_d = fifo_data_q;
    grant_id_d  = grant_id_q;
    wr_count_d  = wr_count_q;
    ack_fire    = 1'b0;
    drop_fire   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          fifo_data_d = req_data[int'(pick_id) * WORDSIZE +: WORDSIZE];
          grant_id_d  = pick_id;
          retry_cnt_d = '0;
          state_d     = S_WRITE;
        end
      end
      S_WRITE: state_d = S_CHECK;
      S_CHECK: begin
        // fifo_overflow now holds the FIFO's verdict on the WRITE cycle.
        if (!fifo_overflow) begin
          ack_fire   = 1'b1;
          wr_count_d = wr_count_q + 16'd1;
          rr_ptr_d   = grant_id_q + ID_W'(1);
          state_d    = S_IDLE;
        end else if (retry_cnt_q == RC_W'(MAX_RETRY)) begin
          drop_fire = 1'b1;
          rr_ptr_d  = grant_id_q + ID_W'(1);
          state_d   = S_IDLE;
        end else begin
          retry_cnt_d = retry_cnt_q + RC_W'(1);
          wait_cnt_d  = WC_W'(RETRY_WAIT - 1);
          state_d     = S_BACKOFF;
        end
      end
      S_BACKOFF: begin
        if (wait_cnt_q == '0) state_d = S_WRITE;
        else                  wait_cnt_d = wait_cnt_q - WC_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state. This keeps write_en aligned
  // with the WRITE cycle and busy aligned with the non-IDLE states.
  always_comb begin
    fifo_we_d = (state_d == S_WRITE);
    busy_d    = (state_d != S_IDLE);
  end

  assign ack           = ack_q;
  assign drop          = drop_q;
  assign fifo_data_in  = fifo_data_q;
  assign fifo_write_en = fifo_we_q;
  assign grant_id      = grant_id_q;
  assign busy          = busy_q;
  assign wr_count      = wr_count_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (default parameters: 4 requesters,
// 8-bit words, RETRY_WAIT=4, MAX_RETRY=7).
module tb_fifo_wr_arbiter;
  logic        wr_clk;
  logic        init;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack, drop;
  logic [7:0]  fifo_data_in;
  logic        fifo_write_en;
  logic        fifo_overflow;
  logic [1:0]  grant_id;
  logic        busy;
  logic [15:0] wr_count;

  int vectors     = 0;
  int miscompares = 0;

  fifo_wr_arbiter dut (
    .wr_clk       (wr_clk),
    .init         (init),
    .req          (req),
    .req_data     (req_data),
    .ack          (ack),
    .drop         (drop),
    .fifo_data_in (fifo_data_in),
    .fifo_write_en(fifo_write_en),
    .fifo_overflow(fifo_overflow),
    .grant_id     (grant_id),
    .busy         (busy),
    .wr_count     (wr_count)
  );

  initial begin
    wr_clk = 1'b0;
    forever #5 wr_clk = ~wr_clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] d4 [4];
    logic [3:0] stray;
    d4[0] = 8'h10; d4[1] = 8'h21; d4[2] = 8'h32; d4[3] = 8'h43;

    // Reset state
    init = 1'b1; req = '0; req_data = '0; fifo_overflow = 1'b0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_we", fifo_write_en, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_cnt", wr_count, 0);
    chk("rst_ackdrop", {ack, drop}, 0);
    chk("rst_data", fifo_data_in, 0);
    init = 1'b0;

    // 1: single request from requester 1
    req = 4'b0010; req_data[15:8] = 8'hA5;
    tick();
    chk("t1_we", fifo_write_en, 1);
    chk("t1_data", fifo_data_in, 8'hA5);
    chk("t1_gid", grant_id, 1);
    chk("t1_busy", busy, 1);
    tick();
    chk("t1_we_off", fifo_write_en, 0);
    chk("t1_ack_early", ack, 0);
    tick();
    chk("t1_ack", ack, 4'b0010);
    chk("t1_cnt", wr_count, 1);
    req = '0;
    tick();
    chk("t1_idle", {busy, fifo_write_en, ack}, 0);

    // Reset pulse so round robin starts at 0
    init = 1'b1;
    tick();
    chk("rst2_cnt", wr_count, 0);
    init = 1'b0;

    // 2: all four requesting, grants rotate 0,1,2,3,0,1
    req = 4'b1111;
    for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = d4[i];
    for (int n = 0; n < 6; n++) begin
      tick();
      chk("t2_we", fifo_write_en, 1);
      chk("t2_gid", grant_id, n % 4);
      chk("t2_data", fifo_data_in, d4[n % 4]);
      tick();
      tick();
      chk("t2_ack", ack, 4'b0001 << (n % 4));
      chk("t2_cnt", wr_count, n + 1);
      if (n == 5) req = '0;
    end
    tick();
    chk("t2_idle", busy, 0);

    // 3: overflow on every write -> 8 writes 6 cycles apart, then drop
    req = 4'b1000; req_data[31:24] = 8'h5C; fifo_overflow = 1'b1;
    stray = '0;
    for (int p = 0; p < 8; p++) begin
      if (p > 0) begin
        for (int k = 0; k < 5; k++) begin
          tick();
          stray = stray | {fifo_write_en, 3'b000} | ack | drop;
        end
      end
      tick();
      chk("t3_we", fifo_write_en, 1);
      chk("t3_data", fifo_data_in, 8'h5C);
    end
    chk("t3_gid", grant_id, 3);
    chk("t3_stray", stray, 0);
    tick();
    chk("t3_we_off", fifo_write_en, 0);
    tick();
    chk("t3_drop", drop, 4'b1000);
    chk("t3_noack", ack, 0);
    chk("t3_cnt", wr_count, 6);
    req = '0; fifo_overflow = 1'b0;
    tick();
    chk("t3_drop_off", {busy, drop}, 0);

    // 4: two rejections then acceptance
    req = 4'b0001; req_data[7:0] = 8'h77; fifo_overflow = 1'b1;
    for (int p = 0; p < 3; p++) begin
      if (p > 0) begin
        for (int k = 0; k < 5; k++) begin
          tick();
          chk("t4_gap", {fifo_write_en, ack, drop}, 0);
        end
      end
      tick();
      chk("t4_we", fifo_write_en, 1);
      chk("t4_data", fifo_data_in, 8'h77);
    end
    fifo_overflow = 1'b0;
    tick();
    tick();
    chk("t4_ack", ack, 4'b0001);
    chk("t4_drop", drop, 0);
    chk("t4_cnt", wr_count, 7);
    req = '0;
    tick();

    // 5: init during BACKOFF, then restart from requester 0
    req = 4'b0100; req_data[23:16] = 8'hE1; fifo_overflow = 1'b1;
    tick();
    chk("t5_we", fifo_write_en, 1);
    chk("t5_gid", grant_id, 2);
    tick();
    tick();
    chk("t5_backoff", {busy, fifo_write_en}, 2'b10);
    init = 1'b1;
    tick();
    chk("t5_busy", busy, 0);
    chk("t5_we_off", fifo_write_en, 0);
    chk("t5_cnt", wr_count, 0);
    chk("t5_ackdrop", {ack, drop}, 0);
    init = 1'b0; fifo_overflow = 1'b0;
    req = 4'b0101; req_data[7:0] = 8'h99;
    tick();
    chk("t5_gid0", grant_id, 0);
    chk("t5_data0", fifo_data_in, 8'h99);
    tick();
    tick();
    chk("t5_ack0", ack, 4'b0001);
    chk("t5_cnt1", wr_count, 1);
    req = 4'b0100;
    tick();
    chk("t5_we2", fifo_write_en, 1);
    chk("t5_gid2", grant_id, 2);
    chk("t5_data2", fifo_data_in, 8'hE1);
    tick();
    tick();
    chk("t5_ack2", ack, 4'b0100);
    chk("t5_cnt2", wr_count, 2);
    req = '0;
    tick();

    // 6: requester 2 held, updates data at each ack; no duplicate writes
    req = 4'b0100; req_data[23:16] = 8'h01;
    for (int w = 1; w <= 3; w++) begin
      tick();
      chk("t6_we", fifo_write_en, 1);
      chk("t6_data", fifo_data_in, w);
      tick();
      tick();
      chk("t6_ack", ack, 4'b0100);
      if (w < 3) req_data[23:16] = 8'(w + 1);
      else       req = '0;
      tick();
      chk("t6_nodup", fifo_write_en, 0);
    end
    chk("t6_cnt", wr_count, 5);
    chk("t6_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
